// File: rtl/carry_resolve_adder_if.sv
// Operand/result handshake bundle for carry_resolve_adder.
// Ovf_o / Clr_i exist only when CRA_STICKY_OVF_EN is defined.
interface carry_resolve_adder_if #(
  parameter int XLEN = 49
);
  logic [XLEN-1:0] Sum_i;
  logic [XLEN-1:0] Carry_i;
  logic            Hidden_i;
  logic            Valid_i;
  logic            Ready_o;
  logic            Flush_i;
  logic [XLEN-1:0] Result_o;
  logic            Cout_o;
  logic            Valid_o;
  logic            Ready_i;
`ifdef CRA_STICKY_OVF_EN
  logic            Ovf_o;
  logic            Clr_i;

  modport slave (
    input  Sum_i, Carry_i, Hidden_i, Valid_i, Flush_i, Ready_i, Clr_i,
    output Ready_o, Result_o, Cout_o, Valid_o, Ovf_o
  );
  modport master (
    output Sum_i, Carry_i, Hidden_i, Valid_i, Flush_i, Ready_i, Clr_i,
    input  Ready_o, Result_o, Cout_o, Valid_o, Ovf_o
  );
`else
  modport slave (
    input  Sum_i, Carry_i, Hidden_i, Valid_i, Flush_i, Ready_i,
    output Ready_o, Result_o, Cout_o, Valid_o
  );
  modport master (
    output Sum_i, Carry_i, Hidden_i, Valid_i, Flush_i, Ready_i,
    input  Ready_o, Result_o, Cout_o, Valid_o
  );
`endif
endinterface

// File: rtl/carry_resolve_adder.sv
// Two-stage carry-resolve adder: low half in stage 1, high half plus hidden MSB in stage 2.
// Optional sticky carry-out flag enabled by CRA_STICKY_OVF_EN.
module carry_resolve_adder #(
  parameter int XLEN = 49,
  parameter int LO_W = XLEN / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  carry_resolve_adder_if.slave  bus
);
  localparam int HI_W = XLEN - LO_W;

  logic            v1_q, v1_d;
  logic [LO_W-1:0] lo_sum_q, lo_sum_d;
  logic            lo_cy_q, lo_cy_d;
  logic [HI_W-1:0] hi_s_q, hi_s_d;
  logic [HI_W-1:0] hi_c_q, hi_c_d;
  logic            hidden_q, hidden_d;

  logic            v2_q, v2_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            cout_q, cout_d;

  logic            adv1, adv2;
  logic [LO_W:0]   lo_add;
  logic [HI_W:0]   hi_add;

  always_comb begin
    adv2 = !v2_q || bus.Ready_i;
    adv1 = !v1_q || adv2;

    lo_add = {1'b0, bus.Sum_i[LO_W-1:0]} + {1'b0, bus.Carry_i[LO_W-1:0]};
    // Hidden MSB sits at bit HI_W of the high add, i.e. weight 2^XLEN overall.
    hi_add = {1'b0, hi_s_q} + {1'b0, hi_c_q} + {{HI_W{1'b0}}, lo_cy_q}
           + {hidden_q, {HI_W{1'b0}}};

    v1_d     = v1_q;
    lo_sum_d = lo_sum_q;
    lo_cy_d  = lo_cy_q;
    hi_s_d   = hi_s_q;
    hi_c_d   = hi_c_q;
    hidden_d = hidden_q;
    v2_d     = v2_q;
    result_d = result_q;
    cout_d   = cout_q;

    if (bus.Flush_i) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else begin
      if (adv1) begin
        v1_d     = bus.Valid_i;
        lo_sum_d = lo_add[LO_W-1:0];
        lo_cy_d  = lo_add[LO_W];
        hi_s_d   = bus.Sum_i[XLEN-1:LO_W];
        hi_c_d   = bus.Carry_i[XLEN-1:LO_W];
        hidden_d = bus.Hidden_i;
      end
      if (adv2) begin
        v2_d     = v1_q;
        result_d = {hi_add[HI_W-1:0], lo_sum_q};
        cout_d   = hi_add[HI_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      lo_sum_q <= '0;
      lo_cy_q  <= 1'b0;
      hi_s_q   <= '0;
      hi_c_q   <= '0;
      hidden_q <= 1'b0;
      v2_q     <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      lo_sum_q <= lo_sum_d;
      lo_cy_q  <= lo_cy_d;
      hi_s_q   <= hi_s_d;
      hi_c_q   <= hi_c_d;
      hidden_q <= hidden_d;
      v2_q     <= v2_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  // Flush empties both stages, so the input side is always open that cycle.
  assign bus.Ready_o  = adv1 || bus.Flush_i;
  assign bus.Valid_o  = v2_q;
  assign bus.Result_o = result_q;
  assign bus.Cout_o   = cout_q;

`ifdef CRA_STICKY_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (bus.Clr_i) ovf_d = 1'b0;
    if (v2_q && bus.Ready_i && cout_q) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign bus.Ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_carry_resolve_adder.sv
// Directed-vector bench for carry_resolve_adder: table loop, streaming, backpressure,
// flush and mid-stream reset, with a queue scoreboard on every output transfer.
module tb_carry_resolve_adder;
  localparam int XLEN = 49;

  typedef struct packed {
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] carry;
    logic            hidden;
    logic [XLEN-1:0] res;
    logic            cout;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  carry_resolve_adder_if #(.XLEN(XLEN)) bus_if ();

  carry_resolve_adder #(.XLEN(XLEN)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  vec_t vecs [12];
  vec_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  int   cur_idx = 0;
  bit   ready_must_hold = 0;
  logic prev_hold = 0;
  logic [XLEN-1:0] prev_res = '0;
  logic prev_cout = 0;
  int   run = 0;
  int   last_run = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void set_vec(int i, logic [XLEN-1:0] s, logic [XLEN-1:0] c,
                                  logic h, logic [XLEN-1:0] r, logic co);
    vecs[i] = '{sum: s, carry: c, hidden: h, res: r, cout: co};
  endfunction

  task automatic apply(int idx);
    cur_idx          = idx;
    bus_if.Sum_i     = vecs[idx].sum;
    bus_if.Carry_i   = vecs[idx].carry;
    bus_if.Hidden_i  = vecs[idx].hidden;
    bus_if.Valid_i   = 1'b1;
  endtask

  // Present an operand and hold it until accepted.
  task automatic push_op(int idx);
    bit acc;
    int guard;
    apply(idx);
    acc = 0;
    guard = 0;
    do begin
      @(negedge clk);
      acc = bus_if.Ready_o;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 50);
    if (!acc) chk("push_timeout", 64'(acc), 64'd1);
    bus_if.Valid_i = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || bus_if.Valid_o) && g < 40) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 40) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: output transfers are checked in order, input transfers enqueue expectations.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus_if.Valid_o && bus_if.Ready_i) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got result 0x%0h with no operand pending", bus_if.Result_o);
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          chk("sb_result", 64'(bus_if.Result_o), 64'(e.res));
          chk("sb_cout", 64'(bus_if.Cout_o), 64'(e.cout));
        end
      end
      if (prev_hold) begin
        chk("hold_valid", 64'(bus_if.Valid_o), 64'd1);
        chk("hold_result", 64'(bus_if.Result_o), 64'(prev_res));
        chk("hold_cout", 64'(bus_if.Cout_o), 64'(prev_cout));
      end
      if (bus_if.Flush_i) exp_q.delete();
      else if (bus_if.Valid_i && bus_if.Ready_o) exp_q.push_back(vecs[cur_idx]);
      if (ready_must_hold) chk("stream_ready", 64'(bus_if.Ready_o), 64'd1);
    end
    prev_hold = !rst && !bus_if.Flush_i && bus_if.Valid_o && !bus_if.Ready_i;
    prev_res  = bus_if.Result_o;
    prev_cout = bus_if.Cout_o;
    if (bus_if.Valid_o) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    set_vec(0,  49'h0_0000_00FF_FFFF, 49'h0_0000_0000_0001, 1'b0, 49'h0_0000_0100_0000, 1'b0);
    set_vec(1,  49'h1_FFFF_FFFF_FFFF, 49'h0_0000_0000_0001, 1'b0, 49'h0_0000_0000_0000, 1'b1);
    set_vec(2,  49'h1_FFFF_FFFF_FFFF, 49'h0_0000_0000_0001, 1'b1, 49'h0_0000_0000_0000, 1'b0);
    set_vec(3,  49'h0_0000_0000_0000, 49'h0_0000_0000_0000, 1'b0, 49'h0_0000_0000_0000, 1'b0);
    set_vec(4,  49'h0_0000_0000_0000, 49'h0_0000_0000_0000, 1'b1, 49'h0_0000_0000_0000, 1'b1);
    set_vec(5,  49'h0_0000_1234_5678, 49'h0_0000_1111_1111, 1'b0, 49'h0_0000_2345_6789, 1'b0);
    set_vec(6,  49'h1_0000_0000_0000, 49'h1_0000_0000_0000, 1'b0, 49'h0_0000_0000_0000, 1'b1);
    set_vec(7,  49'h0_8000_0000_0000, 49'h0_8000_0000_0000, 1'b0, 49'h1_0000_0000_0000, 1'b0);
    set_vec(8,  49'h0_0000_00FF_FFFF, 49'h0_0000_00FF_FFFF, 1'b0, 49'h0_0000_01FF_FFFE, 1'b0);
    set_vec(9,  49'h1_5555_5555_5555, 49'h0_AAAA_AAAA_AAAA, 1'b0, 49'h1_FFFF_FFFF_FFFF, 1'b0);
    set_vec(10, 49'h1_5555_5555_5555, 49'h0_AAAA_AAAA_AAAB, 1'b0, 49'h0_0000_0000_0000, 1'b1);
    set_vec(11, 49'h0_0000_0000_0001, 49'h0_0000_0000_0001, 1'b1, 49'h0_0000_0000_0002, 1'b1);

    rst              = 1'b1;
    bus_if.Sum_i     = '0;
    bus_if.Carry_i   = '0;
    bus_if.Hidden_i  = 1'b0;
    bus_if.Valid_i   = 1'b0;
    bus_if.Flush_i   = 1'b0;
    bus_if.Ready_i   = 1'b1;
`ifdef CRA_STICKY_OVF_EN
    bus_if.Clr_i     = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus_if.Valid_o), 64'd0);
    chk("rst_result", 64'(bus_if.Result_o), 64'd0);
    chk("rst_cout", 64'(bus_if.Cout_o), 64'd0);
`ifdef CRA_STICKY_OVF_EN
    chk("rst_ovf", 64'(bus_if.Ovf_o), 64'd0);
`endif
    rst = 1'b0;
    chk("rst_ready", 64'(bus_if.Ready_o), 64'd1);

    // Isolated vectors: exact 2-cycle latency and value
    for (int i = 0; i < 12; i++) begin
      apply(i);
      @(posedge clk);
      #1;
      bus_if.Valid_i = 1'b0;
      chk($sformatf("tbl%0d_lat1_valid", i), 64'(bus_if.Valid_o), 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 64'(bus_if.Valid_o), 64'd1);
      chk($sformatf("tbl%0d_result", i), 64'(bus_if.Result_o), 64'(vecs[i].res));
      chk($sformatf("tbl%0d_cout", i), 64'(bus_if.Cout_o), 64'(vecs[i].cout));
    end
    @(posedge clk);
    #1;

`ifdef CRA_STICKY_OVF_EN
    bus_if.Clr_i = 1'b1;
    @(posedge clk);
    #1;
    bus_if.Clr_i = 1'b0;
    chk("ovf_cleared", 64'(bus_if.Ovf_o), 64'd0);
    push_op(2);
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_hidden_wrap", 64'(bus_if.Ovf_o), 64'd0);
    push_op(1);
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_full_wrap", 64'(bus_if.Ovf_o), 64'd1);
`endif

    // Streaming: 12 back-to-back operands, Ready_o must stay high
    ready_must_hold = 1;
    for (int i = 0; i < 12; i++) push_op(i);
    ready_must_hold = 0;
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("stream_run_len", 64'(last_run), 64'd12);

    // Backpressure: 3 stalled cycles on a continuous stream
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) push_op(i);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus_if.Ready_i = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_ready_low", 64'(bus_if.Ready_o), 64'd0);
        end
        @(posedge clk);
        #1;
        bus_if.Ready_i = 1'b1;
      end
    join
    drain();
    chk("bp_out_count", 64'(n_out - n0), 64'd8);

    // Flush with two operands in flight
    push_op(5);
    push_op(6);
    chk("pre_flush_valid", 64'(bus_if.Valid_o), 64'd1);
    bus_if.Ready_i = 1'b0;
    bus_if.Flush_i = 1'b1;
    apply(7);
    #1;
    chk("flush_ready", 64'(bus_if.Ready_o), 64'd1);
    @(posedge clk);
    #1;
    bus_if.Flush_i = 1'b0;
    bus_if.Valid_i = 1'b0;
    bus_if.Ready_i = 1'b1;
    chk("flush_valid", 64'(bus_if.Valid_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_no_stale", 64'(bus_if.Valid_o), 64'd0);
    apply(8);
    @(posedge clk);
    #1;
    bus_if.Valid_i = 1'b0;
    @(posedge clk);
    #1;
    chk("post_flush_valid", 64'(bus_if.Valid_o), 64'd1);
    chk("post_flush_result", 64'(bus_if.Result_o), 64'(vecs[8].res));
    @(posedge clk);
    #1;

`ifdef CRA_STICKY_OVF_EN
    push_op(1);
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_before_rst", 64'(bus_if.Ovf_o), 64'd1);
`endif

    // Reset mid-stream
    push_op(10);
    push_op(9);
    push_op(11);
    chk("pre_rst_valid", 64'(bus_if.Valid_o), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_valid", 64'(bus_if.Valid_o), 64'd0);
    chk("midrst_result", 64'(bus_if.Result_o), 64'd0);
    chk("midrst_cout", 64'(bus_if.Cout_o), 64'd0);
    chk("midrst_ready", 64'(bus_if.Ready_o), 64'd1);
`ifdef CRA_STICKY_OVF_EN
    chk("midrst_ovf", 64'(bus_if.Ovf_o), 64'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_output", 64'(bus_if.Valid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
